gate_test_sequencer: RTL and testbench

Self-checking exerciser for a 2-input logic gate (AND/OR/XOR, etc.) in the lab designs. It steps the gate's inputs through all four combinations. Each vector is held for a programmable number of cycles. At the end of each hold, the block samples the gate output and compares it against a 4-bit expected truth table. It reports a per-vector fail mask, an error count and pass/done flags, replacing hand-timed initial-block stimulus with a synthesizable, board-testable controller.

---
 rtl/gate_test_sequencer.sv | 126 ++++++++++++
 tb/tb_gate_test_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/gate_test_sequencer.sv
// rtl/gate_test_sequencer.sv - exerciser that steps a 2-input gate through all vectors and checks its output
//
// Purpose: drives gate inputs {A,B} through vectors 0..3, holds each for
// HOLD_CYCLES clocks, samples gate_o at the end of the hold and compares it
// against a truth table captured at the start of the run.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start             begin a run (sampled in IDLE or DONE only)
//   truth_table[3:0]  expected gate output, bit i for vector i = {A,B}
//   gate_o            output of the gate under test
//   gate_a, gate_b    gate inputs (vector MSB / LSB), 0 outside a run
//   busy, done, pass  run status; pass = done with no mismatches
//   err_count[2:0]    number of mismatching vectors (0..4)
//   fail_mask[3:0]    bit i set if vector i mismatched
//
// Optional build macro: GATE_SEQ_STOP_ON_FAIL_EN - end the run at the first
// mismatching vector instead of applying all four.

module gate_test_sequencer #(
  parameter int HOLD_CYCLES = 20,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] truth_table,
  input  logic       gate_o,
  output logic       gate_a,
  output logic       gate_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_mask
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [1:0]       r_vec;
  logic [CNT_W-1:0] r_hold;
  logic [3:0]       r_tt;

  logic       w_miss;
  logic       w_last;
  logic [3:0] w_mask_nxt;
  logic [2:0] w_err_nxt;
  logic [1:0] w_vec_nxt;

  // Case inequality so an undriven or X gate output is reported as a failure.
  assign w_miss     = (gate_o !== r_tt[r_vec]);
  assign w_mask_nxt = fail_mask | (w_miss ? (4'b0001 << r_vec) : 4'b0000);
  assign w_err_nxt  = err_count + {2'b00, w_miss};
  assign w_vec_nxt  = r_vec + 2'd1;

`ifdef GATE_SEQ_STOP_ON_FAIL_EN
  assign w_last = (r_vec == 2'd3) || w_miss;
`else
  assign w_last = (r_vec == 2'd3);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_vec     <= 2'd0;
      r_hold    <= '0;
      r_tt      <= 4'd0;
      gate_a    <= 1'b0;
      gate_b    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 3'd0;
      fail_mask <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            // Vector 0 is presented on the start edge itself.
            r_state   <= S_RUN;
            r_vec     <= 2'd0;
            r_hold    <= '0;
            r_tt      <= truth_table;
            gate_a    <= 1'b0;
            gate_b    <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 3'd0;
            fail_mask <= 4'd0;
          end
        end
        S_RUN: begin
          if (r_hold == HOLD_LAST) begin
            r_hold    <= '0;
            fail_mask <= w_mask_nxt;
            err_count <= w_err_nxt;
            if (w_last) begin
              r_state <= S_DONE;
              gate_a  <= 1'b0;
              gate_b  <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              pass    <= (w_err_nxt == 3'd0);
            end else begin
              r_vec  <= w_vec_nxt;
              gate_a <= w_vec_nxt[1];
              gate_b <= w_vec_nxt[0];
            end
          end else begin
            r_hold <= r_hold + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_test_sequencer.sv
// tb/tb_gate_test_sequencer.sv - self-checking bench for gate_test_sequencer

module tb_gate_test_sequencer;

  localparam int H = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] i_tt = 4'd0;
  logic [3:0] model = 4'b1000;
  logic       gate_o, gate_a, gate_b, busy, done, pass;
  logic [2:0] err_count;
  logic [3:0] fail_mask;

  logic       start1 = 1'b0;
  logic       g1_o, g1_a, g1_b, busy1, done1, pass1;
  logic [2:0] err1;
  logic [3:0] mask1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Behavioural gate under test: output is the model's truth-table entry.
  assign gate_o = model[{gate_a, gate_b}];
  assign g1_o   = model[{g1_a, g1_b}];

  gate_test_sequencer #(.HOLD_CYCLES(H), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .truth_table(i_tt), .gate_o(gate_o),
    .gate_a(gate_a), .gate_b(gate_b), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_mask(fail_mask)
  );

  gate_test_sequencer #(.HOLD_CYCLES(1), .CNT_W(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .truth_table(4'b1000), .gate_o(g1_o),
    .gate_a(g1_a), .gate_b(g1_b), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_mask(mask1)
  );

  typedef struct {
    logic [3:0] tt;
    logic [3:0] mdl;
    logic [3:0] full_mask;
    string      name;
  } vec_t;

  typedef struct {
    logic [3:0] mask;
    logic [2:0] err;
    logic       pass;
    int         cyc;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, req);
    end
  endtask

  function automatic exp_t expect_of(input logic [3:0] fm);
    exp_t e;
    e.mask = fm;
    e.cyc  = 4 * H;
`ifdef GATE_SEQ_STOP_ON_FAIL_EN
    for (int i = 3; i >= 0; i--) begin
      if (fm[i]) begin
        e.mask = 4'b0001 << i;
        e.cyc  = (i + 1) * H;
      end
    end
`endif
    e.err  = 3'($countones(e.mask));
    e.pass = (e.err == 3'd0);
    return e;
  endfunction

  task automatic run_test(input vec_t v, input bit hold_start);
    exp_t e;
    int   k;
    int   step_bad;
    @(negedge clk);
    i_tt  = v.tt;
    model = v.mdl;
    start = 1'b1;
    @(posedge clk);
    sb.push_back(expect_of(v.full_mask));
    k = 0;
    step_bad = 0;
    while (k < 300) begin
      @(negedge clk);
      if (k == 0) begin
        start = hold_start;
        i_tt  = ~v.tt;  // must not affect the run in progress
        check({v.name, " clear"}, {busy, done, pass, err_count, fail_mask}, {1'b1, 1'b0, 1'b0, 3'd0, 4'd0});
      end
      if (done) begin
        start = 1'b0;
        break;
      end
      if ({gate_a, gate_b} !== 2'(k / H) || busy !== 1'b1) step_bad++;
      @(posedge clk);
      k++;
    end
    start = 1'b0;
    check({v.name, " steps"}, step_bad, 0);
    if (sb.size() == 0) begin
      check({v.name, " scoreboard"}, 0, 1);
    end else begin
      e = sb.pop_front();
      check({v.name, " done_cycle"}, k, e.cyc);
      check({v.name, " fail_mask"}, fail_mask, e.mask);
      check({v.name, " err_count"}, err_count, e.err);
      check({v.name, " pass"}, pass, e.pass);
      check({v.name, " idle_outs"}, {busy, gate_a, gate_b}, 3'b000);
    end
  endtask

  vec_t tbl[6];
  vec_t and_v;

  initial begin
    int k;
    tbl[0] = '{4'b1000, 4'b1000, 4'b0000, "and"};
    tbl[1] = '{4'b1000, 4'b0000, 4'b1000, "stuck0"};
    tbl[2] = '{4'b1000, 4'b1110, 4'b0110, "or"};
    tbl[3] = '{4'b1000, 4'b1111, 4'b0111, "stuck1"};
    tbl[4] = '{4'b0110, 4'b0110, 4'b0000, "xor"};
    tbl[5] = '{4'b0110, 4'b1001, 4'b1111, "xnor"};
    and_v  = tbl[0];

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset outs", {gate_a, gate_b, busy, done, pass, err_count, fail_mask}, 13'd0);
    rst = 1'b0;

    // Table runs; every run after the first restarts straight from DONE.
    foreach (tbl[i]) run_test(tbl[i], 1'b0);

    // Reset in the middle of vector 2's hold.
    @(negedge clk);
    i_tt  = 4'b1000;
    model = 4'b1000;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2 * H + 5) @(posedge clk);
    #2;
    check("mid vec2", {gate_a, gate_b, busy}, 3'b101);
    rst = 1'b1;
    #1;
    check("async reset", {gate_a, gate_b, busy, done, pass, err_count, fail_mask}, 13'd0);
    @(negedge clk);
    rst = 1'b0;
    run_test(and_v, 1'b0);

    // start held through the whole run must not restart it.
    run_test(and_v, 1'b1);

    // HOLD_CYCLES=1 instance.
    @(negedge clk);
    model  = 4'b1000;
    start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    k = 0;
    while (!done1 && k < 20) begin
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    check("hold1 done_cycle", k, 4);
    check("hold1 results", {pass1, err1, mask1, busy1}, {1'b1, 3'd0, 4'd0, 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
